// File: rtl/sample_fifo_pkg.sv
// Shared constants and helpers for the sample FIFO.
package sample_fifo_pkg;

   // Default sample width for a single I or Q component.
   localparam int SAMPLE_W = 12;

   // Width of a packed I/Q pair.
   localparam int IQ_W = 24;

   // Pointer width: address bits plus one wrap bit, so full and empty differ.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Stream bundle around the FIFO: write-side handshake and FWFT read side.
// The slave modport is the FIFO view; master is the surrounding logic.
interface sample_fifo_if
   import sample_fifo_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
);

   logic [WIDTH-1:0] din;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] dout;
   logic             m_tvalid;
   logic             m_tready;

   modport slave (
      input  din,
      input  s_valid,
      input  m_tready,
      output s_ready,
      output dout,
      output m_tvalid
   );

   modport master (
      output din,
      output s_valid,
      output m_tready,
      input  s_ready,
      input  dout,
      input  m_tvalid
   );

endinterface

// File: rtl/sample_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register doubles as the FIFO output word, so it has its own clear.
module sample_fifo_ram #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: registered output, cleared together with the FIFO state.
   always_ff @(posedge clk) begin
      if (clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sample_fifo.sv
// Single-clock FWFT sample FIFO with optional drop-on-full and overflow count.
// The RAM read register is the output word; m_tvalid tracks whether it holds data.
module sample_fifo
   import sample_fifo_pkg::*;
#(
   parameter int WIDTH        = SAMPLE_W,
   parameter int DEPTH        = 512,
   parameter int AFULL_TH     = DEPTH - 8,
   parameter bit DROP_ON_FULL = 1'b1,
   parameter int OVF_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   sample_fifo_if.slave             bus,
   output logic [$clog2(DEPTH)+1:0] level,
   output logic                     almost_full,
   output logic                     full,
   output logic [OVF_W-1:0]         ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int LW = $clog2(DEPTH) + 2;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_nxt;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [PW-1:0]    occ;
   logic [PW-1:0]    occ_nxt;
   logic             ram_empty;
   logic             wr_en;
   logic             rd_en;
   logic             drop;
   logic             m_tvalid_q;
   logic             tvalid_nxt;
   logic [LW-1:0]    level_nxt;
   logic [WIDTH-1:0] dout_q;

   assign bus.s_ready  = DROP_ON_FULL ? 1'b1 : ~full;
   assign bus.dout     = dout_q;
   assign bus.m_tvalid = m_tvalid_q;

   // Decide this cycle's write, read and drop, then the resulting next state.
   always_comb begin
      occ        = wr_ptr - rd_ptr;
      ram_empty  = (occ == '0);
      wr_en      = bus.s_valid & ~full & ~flush;
      drop       = DROP_ON_FULL & bus.s_valid & full & ~flush;
      rd_en      = ~ram_empty & (~m_tvalid_q | bus.m_tready) & ~flush;
      wr_ptr_nxt = wr_ptr + PW'(wr_en);
      rd_ptr_nxt = rd_ptr + PW'(rd_en);
      occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
      tvalid_nxt = m_tvalid_q;
      if (rd_en) begin
         tvalid_nxt = 1'b1;
      end else if (bus.m_tready) begin
         tvalid_nxt = 1'b0;
      end
      level_nxt  = LW'(occ_nxt) + LW'(tvalid_nxt);
   end

   // Pointers, output valid and registered status; flush clears like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         m_tvalid_q  <= 1'b0;
         level       <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         m_tvalid_q  <= tvalid_nxt;
         level       <= level_nxt;
         full        <= (occ_nxt == PW'(DEPTH));
         almost_full <= (occ_nxt >= PW'(AFULL_TH));
      end
   end

   // Saturating count of words discarded while full; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if (drop && (ovf_cnt != '1)) begin
         ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
   end

   sample_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .clr     (rst | flush),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (bus.din),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (dout_q)
   );

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: three DEPTH=16 instances (backpressure,
// drop-on-full, drop-on-full with a 4-bit counter) share one stimulus; a mux
// selects which one the stimulus handshakes with and the monitor checks.
module tb_sample_fifo;

   localparam int W  = 12;
   localparam int D  = 16;
   localparam int LW = $clog2(D) + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          s_valid;
   logic [W-1:0]  din;
   logic          m_tready_base;
   logic          tog;
   logic          tog_en;
   logic          m_tready_a;
   int            sel;

   logic          s_ready_a;
   logic          m_tvalid_a;
   logic          full_a;
   logic          af_a;
   logic [W-1:0]  dout_a;
   logic [LW-1:0] level_a;
   logic [15:0]   ovf_a;

   logic [LW-1:0] level_bp, level_dr, level_st;
   logic          full_bp, full_dr, full_st;
   logic          af_bp, af_dr, af_st;
   logic [15:0]   ovf_bp, ovf_dr;
   logic [3:0]    ovf_st;

   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_word;

   always #5 clk = ~clk;

   sample_fifo_if #(.WIDTH(W)) bus_bp ();
   sample_fifo_if #(.WIDTH(W)) bus_dr ();
   sample_fifo_if #(.WIDTH(W)) bus_st ();

   assign m_tready_a = tog_en ? tog : m_tready_base;

   assign bus_bp.din = din;
   assign bus_bp.s_valid = s_valid;
   assign bus_bp.m_tready = m_tready_a;
   assign bus_dr.din = din;
   assign bus_dr.s_valid = s_valid;
   assign bus_dr.m_tready = m_tready_a;
   assign bus_st.din = din;
   assign bus_st.s_valid = s_valid;
   assign bus_st.m_tready = m_tready_a;

   sample_fifo #(.WIDTH(W), .DEPTH(D), .DROP_ON_FULL(1'b0), .OVF_W(16)) dut_bp (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_bp),
      .level(level_bp), .almost_full(af_bp), .full(full_bp), .ovf_cnt(ovf_bp)
   );

   sample_fifo #(.WIDTH(W), .DEPTH(D), .DROP_ON_FULL(1'b1), .OVF_W(16)) dut_dr (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_dr),
      .level(level_dr), .almost_full(af_dr), .full(full_dr), .ovf_cnt(ovf_dr)
   );

   sample_fifo #(.WIDTH(W), .DEPTH(D), .DROP_ON_FULL(1'b1), .OVF_W(4)) dut_st (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_st),
      .level(level_st), .almost_full(af_st), .full(full_st), .ovf_cnt(ovf_st)
   );

   // Route the selected instance's outputs to the common observation signals.
   always_comb begin
      s_ready_a  = bus_bp.s_ready;
      m_tvalid_a = bus_bp.m_tvalid;
      dout_a     = bus_bp.dout;
      level_a    = level_bp;
      full_a     = full_bp;
      af_a       = af_bp;
      ovf_a      = ovf_bp;
      if (sel == 1) begin
         s_ready_a  = bus_dr.s_ready;
         m_tvalid_a = bus_dr.m_tvalid;
         dout_a     = bus_dr.dout;
         level_a    = level_dr;
         full_a     = full_dr;
         af_a       = af_dr;
         ovf_a      = ovf_dr;
      end else if (sel == 2) begin
         s_ready_a  = bus_st.s_ready;
         m_tvalid_a = bus_st.m_tvalid;
         dout_a     = bus_st.dout;
         level_a    = level_st;
         full_a     = full_st;
         af_a       = af_st;
         ovf_a      = {12'h000, ovf_st};
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until the selected instance accepts it.
   task automatic apply_stimulus(input logic [W-1:0] data);
      int n;
      n = 0;
      din     = data;
      s_valid = 1'b1;
      while (s_ready_a !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_timeout: got s_ready=0 for %0d cycles, expected acceptance", n);
      end else begin
         tick();
      end
      s_valid = 1'b0;
   endtask

   // Wait until every expected word has come out and the FIFO reports empty.
   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || level_a != '0) && n < 500) begin
         tick();
         n++;
      end
      check_output(name, exp_q.size(), 0);
      check_output({name, "_level"}, level_a, 0);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b0;
      tick();
      tick();
      exp_q.delete();
      rst = 1'b0;
   endtask

   // Alternate m_tready every cycle while the wrap test enables it.
   initial begin
      tog = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) tog = ~tog;
      end
   end

   // Monitor: every output handshake pops the scoreboard and compares the word.
   always @(negedge clk) begin
      if (rst === 1'b0 && flush === 1'b0 && m_tvalid_a === 1'b1 && m_tready_a === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no output", dout_a);
         end else begin
            exp_word = exp_q.pop_front();
            check_output("dout_order", dout_a, exp_word);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; din = '0;
      m_tready_base = 1'b0; tog_en = 1'b0; sel = 0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         check_output("rst_m_tvalid", m_tvalid_a, 0);
         check_output("rst_dout", dout_a, 0);
         check_output("rst_level", level_a, 0);
         check_output("rst_full", full_a, 0);
         check_output("rst_afull", af_a, 0);
         check_output("rst_ovf", ovf_a, 0);
         check_output("rst_s_ready", s_ready_a, 1);
      end
      rst = 1'b0;

      $display("[TB] basic order");
      sel = 1;
      m_tready_base = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 1) check_output("latency_early", m_tvalid_a, 0);
         if (i == 2) check_output("latency_first", m_tvalid_a, 1);
         din = W'(i + 1);
         s_valid = 1'b1;
         exp_q.push_back(W'(i + 1));
         tick();
      end
      s_valid = 1'b0;
      wait_drain("basic_drain");

      $display("[TB] backpressure fill");
      do_reset();
      sel = 0;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         exp_q.push_back(W'(12'h100 + k));
         apply_stimulus(W'(12'h100 + k));
         if (k == 8) check_output("afull_below", af_a, 0);
         if (k == 9) check_output("afull_at_8", af_a, 1);
      end
      check_output("bp_level17", level_a, 17);
      check_output("bp_full", full_a, 1);
      check_output("bp_s_ready_low", s_ready_a, 0);
      din = 12'h112;
      s_valid = 1'b1;
      tick();
      check_output("bp_hold_s_ready", s_ready_a, 0);
      check_output("bp_hold_level", level_a, 17);
      s_valid = 1'b0;
      m_tready_base = 1'b1;
      for (int k = 18; k <= 20; k++) begin
         exp_q.push_back(W'(12'h100 + k));
         apply_stimulus(W'(12'h100 + k));
      end
      wait_drain("bp_drain");
      check_output("bp_ovf_zero", ovf_a, 0);

      $display("[TB] overflow count");
      do_reset();
      sel = 1;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         din = W'(k);
         s_valid = 1'b1;
         if (k <= 17) exp_q.push_back(W'(k));
         tick();
      end
      s_valid = 1'b0;
      check_output("ovf_level17", level_a, 17);
      check_output("ovf_cnt8", ovf_a, 8);
      check_output("ovf_s_ready", s_ready_a, 1);
      m_tready_base = 1'b1;
      wait_drain("ovf_drain");

      do_reset();
      sel = 2;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 37; k++) begin
         din = W'(k);
         s_valid = 1'b1;
         if (k <= 17) exp_q.push_back(W'(k));
         tick();
      end
      s_valid = 1'b0;
      check_output("ovf_saturate", ovf_a, 15);
      m_tready_base = 1'b1;
      wait_drain("sat_drain");

      $display("[TB] wrap-around");
      do_reset();
      sel = 0;
      tog_en = 1'b1;
      for (int k = 0; k < 100; k++) begin
         exp_q.push_back(W'(12'h200 + k));
         apply_stimulus(W'(12'h200 + k));
      end
      wait_drain("wrap_drain");
      tog_en = 1'b0;

      $display("[TB] flush and reset mid-stream");
      do_reset();
      sel = 1;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         din = W'(12'h300 + k);
         s_valid = 1'b1;
         if (k <= 17) exp_q.push_back(W'(12'h300 + k));
         tick();
      end
      s_valid = 1'b0;
      check_output("fl_ovf3", ovf_a, 3);
      m_tready_base = 1'b1;
      repeat (12) tick();
      m_tready_base = 1'b0;
      check_output("fl_level5", level_a, 5);
      flush = 1'b1;
      din = 12'hEEE;
      s_valid = 1'b1;
      exp_q.delete();
      tick();
      flush = 1'b0;
      s_valid = 1'b0;
      check_output("fl_m_tvalid", m_tvalid_a, 0);
      check_output("fl_level", level_a, 0);
      check_output("fl_ovf_kept", ovf_a, 3);
      check_output("fl_full", full_a, 0);
      check_output("fl_dout", dout_a, 0);
      tick();
      tick();
      check_output("fl_write_dropped", level_a, 0);
      check_output("fl_still_empty", m_tvalid_a, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("rst_ovf_clear", ovf_a, 0);
      m_tready_base = 1'b1;
      exp_q.push_back(12'h0AB);
      apply_stimulus(12'h0AB);
      wait_drain("fl_after_drain");

      $display("[TB] simultaneous at full");
      do_reset();
      sel = 1;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         din = W'(12'h400 + k);
         s_valid = 1'b1;
         exp_q.push_back(W'(12'h400 + k));
         tick();
      end
      check_output("sim_dr_full", full_a, 1);
      m_tready_base = 1'b1;
      din = 12'h4FF;
      tick();
      check_output("sim_dr_full_clear", full_a, 0);
      check_output("sim_dr_ovf1", ovf_a, 1);
      din = 12'h4FE;
      exp_q.push_back(12'h4FE);
      tick();
      s_valid = 1'b0;
      check_output("sim_dr_next_ok", ovf_a, 1);
      wait_drain("sim_dr_drain");

      do_reset();
      sel = 0;
      m_tready_base = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         din = W'(12'h500 + k);
         s_valid = 1'b1;
         exp_q.push_back(W'(12'h500 + k));
         tick();
      end
      m_tready_base = 1'b1;
      din = 12'h5FF;
      exp_q.push_back(12'h5FF);
      check_output("sim_bp_s_ready_low", s_ready_a, 0);
      tick();
      check_output("sim_bp_full_clear", full_a, 0);
      check_output("sim_bp_s_ready_high", s_ready_a, 1);
      tick();
      s_valid = 1'b0;
      check_output("sim_bp_ovf_zero", ovf_a, 0);
      wait_drain("sim_bp_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
